// File: rtl/plab3_mem_line_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : plab3_mem_line_responder_pkg
//  Description : Shared types and helpers for the line-granularity memory
//                responder. Provides the vc-mem message type codes, the FSM
//                state type, message width helpers and the len-to-byte-enable
//                conversion used by the write path.
//  Revision    : 1.0 - initial release
// ============================================================================
package plab3_mem_line_responder_pkg;

    // vc-mem message type codes
    localparam logic [2:0] c_type_read       = 3'd0;
    localparam logic [2:0] c_type_write      = 3'd1;
    localparam logic [2:0] c_type_write_init = 3'd2;

    localparam int c_line_nbytes = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Request layout: {type[2:0], opaque, addr, len[3:0], data}
    function automatic int req_nbits(input int o, input int a, input int c);
        return 3 + o + a + 4 + c;
    endfunction

    // Response layout: {type[2:0], opaque, len[3:0], data}
    function automatic int resp_nbits(input int o, input int c);
        return 3 + o + 4 + c;
    endfunction

    // len==0 means a full line; otherwise only bytes 0..len-1 are written.
    function automatic logic [15:0] len_to_byte_en(input logic [3:0] len);
        logic [16:0] mask;
        if (len == 4'd0) begin
            return 16'hFFFF;
        end
        mask = (17'd1 << len) - 17'd1;
        return mask[15:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/plab3_mem_line_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : plab3_mem_line_responder_if
//  Description : memreq/memresp val/rdy bundle between a requester (master)
//                and the line responder (slave).
//                memreq_msg  : request message  (master -> slave)
//                memreq_val  : request valid    (master -> slave)
//                memreq_rdy  : request ready    (slave  -> master)
//                memresp_msg : response message (slave  -> master)
//                memresp_val : response valid   (slave  -> master)
//                memresp_rdy : response ready   (master -> slave)
//  Revision    : 1.0 - initial release
// ============================================================================
interface plab3_mem_line_responder_if
    import plab3_mem_line_responder_pkg::*;
#(
    parameter int p_opaque_nbits = 8,
    parameter int abw            = 32,
    parameter int clw            = 128
) ();

    localparam int c_req_nbits  = req_nbits(p_opaque_nbits, abw, clw);
    localparam int c_resp_nbits = resp_nbits(p_opaque_nbits, clw);

    logic [c_req_nbits-1:0]  memreq_msg;
    logic                    memreq_val;
    logic                    memreq_rdy;
    logic [c_resp_nbits-1:0] memresp_msg;
    logic                    memresp_val;
    logic                    memresp_rdy;

    modport master (
        output memreq_msg,
        output memreq_val,
        input  memreq_rdy,
        input  memresp_msg,
        input  memresp_val,
        output memresp_rdy
    );

    modport slave (
        input  memreq_msg,
        input  memreq_val,
        output memreq_rdy,
        output memresp_msg,
        output memresp_val,
        input  memresp_rdy
    );

endinterface
`default_nettype wire

// File: rtl/plab3_mem_line_store.sv
`default_nettype none
// ============================================================================
//  Module      : plab3_mem_line_store
//  Description : nlines x 128-bit line array, one synchronous byte-masked
//                write port and one combinational read port. No reset: the
//                contents survive responder resets.
//  Ports       : clk          - clock
//                i_wr_en      - write strobe
//                i_wr_idx     - write line index
//                i_wr_byte_en - per-byte write enable (bit b -> byte b)
//                i_wr_data    - write line data
//                i_rd_idx     - read line index
//                o_rd_data    - read line data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module plab3_mem_line_store #(
    parameter int p_nlines = 256,
    parameter int p_idx_w  = 8
) (
    input  wire logic               clk,
    input  wire logic               i_wr_en,
    input  wire logic [p_idx_w-1:0] i_wr_idx,
    input  wire logic [15:0]        i_wr_byte_en,
    input  wire logic [127:0]       i_wr_data,
    input  wire logic [p_idx_w-1:0] i_rd_idx,
    output logic      [127:0]       o_rd_data
);

    logic [127:0] lines_q [p_nlines];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < 16; b++) begin
                if (i_wr_byte_en[b]) begin
                    lines_q[i_wr_idx][8*b +: 8] <= i_wr_data[8*b +: 8];
                end
            end
        end
    end

    assign o_rd_data = lines_q[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/plab3_mem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : plab3_mem_line_responder
//  Description : Line-granularity memory responder. Accepts one vc-mem line
//                request at a time, performs the store access at the accept
//                edge, waits p_latency cycles and then presents a response
//                held until memresp_rdy.
//  Ports       : clk   - clock, rising edge
//                reset - asynchronous reset, active low
//                mem   - memreq/memresp bundle (slave side)
//  Revision    : 1.0 - initial release
// ============================================================================
module plab3_mem_line_responder
    import plab3_mem_line_responder_pkg::*;
#(
    parameter int p_mem_nbytes   = 4096,
    parameter int p_opaque_nbits = 8,
    parameter int p_latency      = 2,
    parameter int abw            = 32,
    parameter int clw            = 128
) (
    input wire logic                    clk,
    input wire logic                    reset,
    plab3_mem_line_responder_if.slave   mem
);

    localparam int c_nlines     = p_mem_nbytes / c_line_nbytes;
    localparam int c_idx_w      = (c_nlines > 1) ? $clog2(c_nlines) : 1;
    localparam int c_resp_nbits = resp_nbits(p_opaque_nbits, clw);

    // Request field positions, data at the LSB end
    localparam int c_len_lsb  = clw;
    localparam int c_addr_lsb = clw + 4;
    localparam int c_opq_lsb  = clw + 4 + abw;
    localparam int c_type_lsb = clw + 4 + abw + p_opaque_nbits;

    localparam logic [7:0] c_lat_m1 = (p_latency > 0) ? 8'(p_latency - 1) : 8'd0;

    // ------------------------------------------------------------------
    // Request field decode
    // ------------------------------------------------------------------
    logic [2:0]                w_req_type;
    logic [p_opaque_nbits-1:0] w_req_opq;
    logic [abw-1:0]            w_req_addr;
    logic [3:0]                w_req_len;
    logic [clw-1:0]            w_req_data;
    logic [c_idx_w-1:0]        w_idx;
    logic                      w_unused_addr;

    assign w_req_type = mem.memreq_msg[c_type_lsb +: 3];
    assign w_req_opq  = mem.memreq_msg[c_opq_lsb +: p_opaque_nbits];
    assign w_req_addr = mem.memreq_msg[c_addr_lsb +: abw];
    assign w_req_len  = mem.memreq_msg[c_len_lsb +: 4];
    assign w_req_data = mem.memreq_msg[clw-1:0];

    // Byte offset and any bits above the store size are ignored, giving
    // modulo-store-size wrap.
    assign w_idx         = w_req_addr[4 +: c_idx_w];
    assign w_unused_addr = ^w_req_addr;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                  state_q,    state_d;
    logic [7:0]              cnt_q,      cnt_d;
    logic [c_resp_nbits-1:0] resp_msg_q, resp_msg_d;

    logic         w_req_rdy;
    logic         w_wr_en;
    logic [127:0] w_rd_data;

    // Ready is withheld while reset is asserted so nothing can be accepted
    // (and no write can land) during reset.
    assign w_req_rdy = (state_q == ST_IDLE) && reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            resp_msg_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_msg_q <= resp_msg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        resp_msg_d = resp_msg_q;
        w_wr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem.memreq_val && w_req_rdy) begin
                    // Read data is captured now, so a write later in time
                    // cannot disturb the pending response.
                    resp_msg_d = {w_req_type, w_req_opq, w_req_len,
                                  (w_req_type == c_type_read) ? w_rd_data : {clw{1'b0}}};
                    w_wr_en    = (w_req_type == c_type_write) ||
                                 (w_req_type == c_type_write_init);
                    if (p_latency > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = c_lat_m1;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_RESP: begin
                if (mem.memresp_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign mem.memreq_rdy  = w_req_rdy;
    assign mem.memresp_val = (state_q == ST_RESP);
    assign mem.memresp_msg = resp_msg_q;

    // ------------------------------------------------------------------
    // Line store
    // ------------------------------------------------------------------
    plab3_mem_line_store #(
        .p_nlines (c_nlines),
        .p_idx_w  (c_idx_w)
    ) u_store (
        .clk          (clk),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (w_idx),
        .i_wr_byte_en (len_to_byte_en(w_req_len)),
        .i_wr_data    (w_req_data),
        .i_rd_idx     (w_idx),
        .o_rd_data    (w_rd_data)
    );

endmodule
`default_nettype wire

// File: tb/tb_plab3_mem_line_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_plab3_mem_line_responder
//  Description : Self-checking bench for the line responder. Three DUTs:
//                  0: 4096 B store, latency 2
//                  1:  256 B store, latency 0
//                  2:  256 B store, latency 4
//                Expected responses come from a byte-level line model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_plab3_mem_line_responder;

    logic clk;
    logic rst_n    [3];
    logic [174:0] req_msg  [3];
    logic         req_val  [3];
    logic         req_rdy  [3];
    logic [142:0] resp_msg [3];
    logic         resp_val [3];
    logic         resp_rdy [3];

    int lat_cfg    [3] = '{2, 0, 4};
    int nlines_cfg [3] = '{256, 16, 16};

    logic [127:0] model_mem [3][256];

    int n_checks = 0;
    int n_pass   = 0;

    plab3_mem_line_responder_if #(.p_opaque_nbits(8), .abw(32), .clw(128)) if_a ();
    plab3_mem_line_responder_if #(.p_opaque_nbits(8), .abw(32), .clw(128)) if_b ();
    plab3_mem_line_responder_if #(.p_opaque_nbits(8), .abw(32), .clw(128)) if_c ();

    assign if_a.memreq_msg  = req_msg[0];
    assign if_a.memreq_val  = req_val[0];
    assign if_a.memresp_rdy = resp_rdy[0];
    assign req_rdy[0]       = if_a.memreq_rdy;
    assign resp_val[0]      = if_a.memresp_val;
    assign resp_msg[0]      = if_a.memresp_msg;

    assign if_b.memreq_msg  = req_msg[1];
    assign if_b.memreq_val  = req_val[1];
    assign if_b.memresp_rdy = resp_rdy[1];
    assign req_rdy[1]       = if_b.memreq_rdy;
    assign resp_val[1]      = if_b.memresp_val;
    assign resp_msg[1]      = if_b.memresp_msg;

    assign if_c.memreq_msg  = req_msg[2];
    assign if_c.memreq_val  = req_val[2];
    assign if_c.memresp_rdy = resp_rdy[2];
    assign req_rdy[2]       = if_c.memreq_rdy;
    assign resp_val[2]      = if_c.memresp_val;
    assign resp_msg[2]      = if_c.memresp_msg;

    plab3_mem_line_responder #(.p_mem_nbytes(4096), .p_opaque_nbits(8), .p_latency(2),
                               .abw(32), .clw(128))
        dut_a (.clk(clk), .reset(rst_n[0]), .mem(if_a));
    plab3_mem_line_responder #(.p_mem_nbytes(256), .p_opaque_nbits(8), .p_latency(0),
                               .abw(32), .clw(128))
        dut_b (.clk(clk), .reset(rst_n[1]), .mem(if_b));
    plab3_mem_line_responder #(.p_mem_nbytes(256), .p_opaque_nbits(8), .p_latency(4),
                               .abw(32), .clw(128))
        dut_c (.clk(clk), .reset(rst_n[2]), .mem(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: a line is a bag of 16 bytes; writes replace the first
    // len (or all 16) bytes, reads return the whole line.
    function automatic logic [142:0] model_apply(input int d, input logic [2:0] typ,
                                                 input logic [7:0] opq, input logic [31:0] addr,
                                                 input logic [3:0] len, input logic [127:0] data);
        int           idx;
        int           nb;
        logic [127:0] line;
        logic [127:0] rdata;
        idx   = int'(addr / 16) % nlines_cfg[d];
        line  = model_mem[d][idx];
        rdata = '0;
        if (typ == 3'd0) begin
            rdata = line;
        end else if (typ == 3'd1 || typ == 3'd2) begin
            nb = (len == 4'd0) ? 16 : int'(len);
            for (int i = 0; i < nb; i++) line[8*i +: 8] = data[8*i +: 8];
            model_mem[d][idx] = line;
        end
        return {typ, opq, len, rdata};
    endfunction

    // Drives one request, measures edges from accept to response-valid,
    // optionally holds backpressure, then drains the response.
    task automatic txn(input int d, input logic [2:0] typ, input logic [7:0] opq,
                       input logic [31:0] addr, input logic [3:0] len, input logic [127:0] data,
                       input int hold, output int lat, output logic [142:0] resp,
                       output logic [142:0] exp, output bit stable, output bit idle_after);
        int w;
        w = 0;
        while (!req_rdy[d] && w < 20) begin
            @(posedge clk); #1; w++;
        end
        req_msg[d]  = {typ, opq, addr, len, data};
        req_val[d]  = 1'b1;
        resp_rdy[d] = 1'b0;
        exp = model_apply(d, typ, opq, addr, len, data);
        @(posedge clk); #1;
        req_val[d] = 1'b0;
        lat = 0;
        while (!resp_val[d] && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        if (!resp_val[d]) lat = -1;
        resp   = resp_msg[d];
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            if (!resp_val[d] || resp_msg[d] !== resp || req_rdy[d]) stable = 1'b0;
        end
        resp_rdy[d] = 1'b1;
        @(posedge clk); #1;
        resp_rdy[d] = 1'b0;
        idle_after = !resp_val[d] && req_rdy[d];
    endtask

    task automatic test_reset();
        for (int d = 0; d < 3; d++) begin
            rst_n[d] = 1'b0; req_val[d] = 1'b0; resp_rdy[d] = 1'b0; req_msg[d] = '0;
        end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                n_checks++;
                if (resp_val[d] !== 1'b0 || resp_msg[d] !== '0)
                    $display("FAIL reset_outputs dut%0d cyc%0d: val=%b msg=%h, want val=0 msg=0",
                             d, c, resp_val[d], resp_msg[d]);
                else n_pass++;
            end
        end
        for (int d = 0; d < 3; d++) rst_n[d] = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_checks++;
            if (req_rdy[d] !== 1'b1)
                $display("FAIL reset_release_rdy dut%0d: rdy=%b want 1", d, req_rdy[d]);
            else n_pass++;
        end
    endtask

    task automatic test_preload();
        int lat; logic [142:0] r, e; bit s, i; int errs;
        for (int d = 0; d < 3; d++) begin
            errs = 0;
            for (int l = 0; l < nlines_cfg[d]; l++) begin
                txn(d, 3'd2, 8'(l), 32'(l * 16), 4'd0,
                    {$urandom, $urandom, $urandom, $urandom}, 0, lat, r, e, s, i);
                if (r !== e || lat !== lat_cfg[d] || !i) errs++;
            end
            n_checks++;
            if (errs !== 0) $display("FAIL preload dut%0d: %0d bad txns, want 0", d, errs);
            else n_pass++;
        end
    endtask

    task automatic test_write_read();
        int lat; logic [142:0] r, e; bit s, i;
        logic [127:0] pat;
        pat = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        txn(0, 3'd1, 8'h05, 32'h40, 4'd0, pat, 0, lat, r, e, s, i);
        n_checks++;
        if (r !== {3'd1, 8'h05, 4'd0, 128'd0})
            $display("FAIL write_resp: got %h want %h", r, {3'd1, 8'h05, 4'd0, 128'd0});
        else n_pass++;
        n_checks++;
        if (lat !== 2) $display("FAIL write_latency: got %0d want 2", lat);
        else n_pass++;
        txn(0, 3'd0, 8'h06, 32'h40, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (r !== {3'd0, 8'h06, 4'd0, pat})
            $display("FAIL read_after_write: got %h want %h", r, {3'd0, 8'h06, 4'd0, pat});
        else n_pass++;
    endtask

    task automatic test_partial_write();
        int lat; logic [142:0] r, e; bit s, i;
        txn(0, 3'd1, 8'h07, 32'h40, 4'd4, {96'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 32'hDEADBEEF},
            0, lat, r, e, s, i);
        txn(0, 3'd0, 8'h08, 32'h40, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (r[127:0] !== 128'h00112233_44556677_8899AABB_DEADBEEF)
            $display("FAIL partial_write: got %h want %h", r[127:0],
                     128'h00112233_44556677_8899AABB_DEADBEEF);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int lat; logic [142:0] r, e; bit s, i;
        txn(0, 3'd0, 8'h33, 32'h40, 4'd0, 128'd0, 5, lat, r, e, s, i);
        n_checks++;
        if (s !== 1'b1) $display("FAIL backpressure_stable: got %b want 1", s);
        else n_pass++;
        n_checks++;
        if (i !== 1'b1) $display("FAIL backpressure_release_idle: got %b want 1", i);
        else n_pass++;
        n_checks++;
        if (r !== e) $display("FAIL backpressure_resp: got %h want %h", r, e);
        else n_pass++;
        txn(0, 3'd0, 8'h34, 32'h80, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (lat !== 2 || r !== e)
            $display("FAIL backpressure_next_txn: lat=%0d resp=%h want lat=2 resp=%h", lat, r, e);
        else n_pass++;
    endtask

    task automatic test_wrap();
        int lat; logic [142:0] r, e; bit s, i;
        logic [127:0] pat;
        pat = {$urandom, $urandom, $urandom, $urandom};
        txn(1, 3'd1, 8'h11, 32'h100, 4'd0, pat, 0, lat, r, e, s, i);
        txn(1, 3'd0, 8'h12, 32'h000, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (r[127:0] !== pat) $display("FAIL wrap_alias: got %h want %h", r[127:0], pat);
        else n_pass++;
        for (int d = 0; d < 2; d++) begin
            txn(d, 3'd0, 8'h13, 32'h4F, 4'd0, 128'd0, 0, lat, r, e, s, i);
            n_checks++;
            if (r !== e) $display("FAIL offset_ignored dut%0d: got %h want %h", d, r, e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_latency();
        int lat; logic [142:0] r, e; bit s, i;
        txn(1, 3'd1, 8'h21, 32'h30, 4'd9, {$urandom, $urandom, $urandom, $urandom},
            0, lat, r, e, s, i);
        n_checks++;
        if (lat !== 0) $display("FAIL zero_latency: got %0d want 0", lat);
        else n_pass++;
        txn(2, 3'd0, 8'h22, 32'h30, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (lat !== 4 || r !== e)
            $display("FAIL latency4: lat=%0d resp=%h want lat=4 resp=%h", lat, r, e);
        else n_pass++;
    endtask

    task automatic test_reset_in_wait();
        int lat; logic [142:0] r, e; bit s, i; bit quiet;
        logic [127:0] pat;
        pat = {$urandom, $urandom, $urandom, $urandom};
        req_msg[2] = {3'd1, 8'h44, 32'h20, 4'd0, pat};
        req_val[2] = 1'b1;
        e = model_apply(2, 3'd1, 8'h44, 32'h20, 4'd0, pat);
        @(posedge clk); #1;
        req_val[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b0;
        #1;
        n_checks++;
        if (resp_val[2] !== 1'b0) $display("FAIL reset_in_wait_val: got %b want 0", resp_val[2]);
        else n_pass++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n[2] = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (resp_val[2] !== 1'b0 || req_rdy[2] !== 1'b1) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1) $display("FAIL reset_in_wait_idle: got %b want 1", quiet);
        else n_pass++;
        txn(2, 3'd0, 8'h45, 32'h20, 4'd0, 128'd0, 0, lat, r, e, s, i);
        n_checks++;
        if (r[127:0] !== pat)
            $display("FAIL reset_keeps_write: got %h want %h", r[127:0], pat);
        else n_pass++;
    endtask

    task automatic test_random();
        int lat; logic [142:0] r, e; bit s, i;
        logic [2:0] typ;
        int d;
        logic [2:0] types [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd3, 3'd7};
        for (int n = 0; n < 60; n++) begin
            d   = int'($urandom_range(0, 2));
            typ = types[$urandom_range(0, 5)];
            txn(d, typ, 8'($urandom), $urandom, 4'($urandom),
                {$urandom, $urandom, $urandom, $urandom},
                int'($urandom_range(0, 2)), lat, r, e, s, i);
            n_checks++;
            if (r !== e) $display("FAIL random_resp #%0d dut%0d: got %h want %h", n, d, r, e);
            else n_pass++;
            n_checks++;
            if (lat !== lat_cfg[d] || !s || !i)
                $display("FAIL random_timing #%0d dut%0d: lat=%0d stable=%b idle=%b want lat=%0d 1 1",
                         n, d, lat, s, i, lat_cfg[d]);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_read();
        test_partial_write();
        test_backpressure();
        test_wrap();
        test_zero_latency();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plab3_mem_line_responder.md
Name: plab3_mem_line_responder

Overview:
Line-granularity memory responder. It is the far end of the prefetch buffer's memreq/memresp interface.
- Accepts 128-bit cacheline requests in the standard vc-mem message format.
- Services each request from an internal line store after a configurable fixed latency.
- Returns one response per request over a val/rdy handshake.
- Used as backing memory for prefetch buffer and cache test harnesses and small systems.

Parameters:
- p_mem_nbytes, 4096, store size in bytes; must be a multiple of 16 and a power of two.
- p_opaque_nbits, 8, opaque field width, echoed unchanged into the response.
- p_latency, 2, extra wait cycles between accept and response-valid; legal range 0..255.
- abw, 32, address width.
- clw, 128, line width (data field width).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- memreq_msg  in  `VC_MEM_REQ_MSG_NBITS(o,abw,clw)` (175 at defaults)  fields {type[2:0], opaque, addr, len[3:0], data[127:0]}.
- memreq_val  in  1  request valid.
- memreq_rdy  out  1  request ready.
- memresp_msg  out  `VC_MEM_RESP_MSG_NBITS(o,clw)` (143 at defaults)  fields {type, opaque, len, data}.
- memresp_val  out  1  response valid.
- memresp_rdy  in  1  response ready.

Behaviour:
- Reset (asynchronous, while reset==0):
  - state goes to IDLE; latency counter = 0.
  - memresp_val = 0; memreq_rdy = 1 once reset is released.
  - memresp_msg register = 0.
  - Store contents are NOT reset.
- Reset asserted mid-transaction: the pending request and response are dropped with no response. A write already committed at accept stays committed.
- FSM states and transitions:
  - IDLE: memreq_rdy=1, memresp_val=0. On memreq_val at the edge, accept and latch the request. Go to WAIT if p_latency>0, else go to RESP.
  - WAIT: memreq_rdy=0, memresp_val=0. Counter loads p_latency-1 on entry and decrements each cycle. When the counter is 0, go to RESP.
  - RESP: memresp_val=1, memreq_rdy=0. memresp_msg is stable while val is high and rdy is low. On memresp_rdy at the edge, go to IDLE.
- Latency:
  - Accept at edge E0 gives memresp_val high in the cycle after edge E0+p_latency.
  - Minimum period per transaction is p_latency+2 cycles.
  - No overlap between transactions: rdy is asserted only in IDLE.
- Store access:
  - Performed at the accept edge.
  - Line index = addr[4+log2(nlines)-1:4]; addr[3:0] is ignored.
  - Out-of-range upper address bits are ignored, so accesses wrap modulo store size.
- Per message type:
  - READ (0): capture the full line into the response data; resp type=READ.
  - WRITE (1) / WRITE_INIT (2): len=0 writes all 16 bytes; len=n (1..15) writes bytes 0..n-1 only. Resp type echoes the request type; resp data=0.
  - Any other type: no store change; resp echoes the type; resp data=0.
- Response opaque and len always echo the latched request fields.
- A read after a write to the same line in the previous transaction returns the new data.

Decomposition:
- Shared header (vc-mem-msgs.v, already shared) supplies the message macros and type constants READ/WRITE/WRITE_INIT.
- FSM state encodings are localparams in the module.
- One natural sub-module: plab3_mem_line_store.
  - nlines x 128-bit array with one read port and one write port.
  - 16-bit byte write enable.
  - Synchronous write, combinational read, no reset.
- Top level holds the FSM, latency counter, request latch and response register.

Test Plan:
- Reset, then IDLE: memreq_rdy=1, memresp_val=0; hold reset=0 for 3 cycles and the outputs stay at reset values.
- WRITE addr 0x40, len 0, data 0x00112233_44556677_8899AABB_CCDDEEFF, opaque 0x5 -> after 3 cycles (p_latency=2) val=1 with resp {WRITE, 0x5, len 0, data 0}. Then READ 0x40 returns the same 128-bit data with opaque echoed.
- Partial write len=4 of data 0xDEADBEEF at 0x40 -> a READ 0x40 returns the low 4 bytes replaced and bytes 4..15 unchanged.
- Backpressure: hold memresp_rdy=0 for 5 cycles in RESP -> val stays 1, msg stable, memreq_rdy=0. Release -> IDLE next cycle and a new request is accepted.
- Wrap/aliasing: with p_mem_nbytes=256, WRITE 0x100 then READ 0x000 -> same data. Also READ 0x4F returns line 0x40.
- p_latency=0: accept at E0 -> val high in the following cycle. Then reset=0 asserted in WAIT (p_latency=4) -> no response, IDLE after release.
